bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/arb_pkg.sv | 27 ++
 rtl/dma_rr_sel.sv | 41 ++++
 rtl/bus_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the bus arbiter.
//   - arb_state_e : arbiter FSM state encoding (CPU / SWITCH / DMA)
//   - OWN_*       : bus mux select codes driven on owner_o
//   - *_W         : counter widths sized for the largest legal parameter
//                   values (CPU_SLOT, BURST_MAX <= 255, TMO_CYCLES <= 1023)
package arb_pkg;

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_DMA    = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWN_CPU  = 2'b00;
    localparam logic [1:0] OWN_DMA0 = 2'b01;
    localparam logic [1:0] OWN_DMA1 = 2'b10;

    // Bits needed to hold the value max_val without wrapping.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    localparam int unsigned SLOT_W  = cnt_w(255);
    localparam int unsigned BURST_W = cnt_w(255);
    localparam int unsigned TMO_W   = cnt_w(1023);

endpackage

// File: rtl/dma_rr_sel.sv
// dma_rr_sel: two-way round-robin pick between the DMA masters.
//   clk_p     : clock (rising edge)
//   rst       : asynchronous active-high reset
//   req       : per-master request
//   grant_en  : pulse when a DMA master is actually granted
//   grant_idx : index of the master being granted (0 = DMA0, 1 = DMA1)
//   pick_idx  : combinational winner index
//   pick_any  : at least one master is requesting
module dma_rr_sel (
    input  logic       clk_p,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    input  logic       grant_idx,
    output logic       pick_idx,
    output logic       pick_any
);

    // Last-served bookkeeping, stored as the master favoured on a tie
    // (i.e. the one NOT served last). Reset favours DMA0.
    logic prefer_q;

    always_comb begin
        pick_any = |req;
        case (req)
            2'b01:   pick_idx = 1'b0;
            2'b10:   pick_idx = 1'b1;
            2'b11:   pick_idx = prefer_q;
            default: pick_idx = 1'b0;
        endcase
    end

    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            prefer_q <= 1'b0;
        end else if (grant_en) begin
            prefer_q <= ~grant_idx;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU / 2x DMA bus arbiter with a one-cycle SWITCH gap between
// every ownership change. The CPU always regains the bus after a DMA tenure.
//   wb_clk_i   : bus clock (rising edge)
//   wb_rst_i   : asynchronous active-high reset
//   cpu_cyc_i  : CPU cycle strobe
//   cpu_gnt_o  : CPU grant
//   dma_req_i  : DMA master requests
//   dma_gnt_o  : DMA grants, one-hot or zero
//   bus_ack_i  : global bus acknowledge
//   owner_o    : mux select (00 CPU, 01 DMA0, 10 DMA1)
//   tmo_o      : one-cycle forced-release pulse
//   dbg_state  : current FSM state
// Optional feature: define ARB_TIMEOUT_EN to enable the stall timeout
// (TMO_CYCLES cycles without ack forces a release). Without it tmo_o is 0.
//
// Handshake: a DMA master holds dma_req_i high for its whole cycle; it may
// drive the bus only while its dma_gnt_o bit is high, and each cycle with
// bus_ack_i high while its request is high completes one transfer.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned CPU_SLOT   = 4,
    parameter int unsigned BURST_MAX  = 8,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cpu_cyc_i,
    output logic       cpu_gnt_o,
    input  logic [1:0] dma_req_i,
    output logic [1:0] dma_gnt_o,
    input  logic       bus_ack_i,
    output logic [1:0] owner_o,
    output logic       tmo_o,
    output arb_state_e dbg_state
);

    if (CPU_SLOT < 1 || CPU_SLOT > 255) begin : g_bad_slot
        $error("bus_arbiter: CPU_SLOT out of range 1..255");
    end
    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst
        $error("bus_arbiter: BURST_MAX out of range 1..255");
    end
    if (TMO_CYCLES < 2 || TMO_CYCLES > 1023) begin : g_bad_tmo
        $error("bus_arbiter: TMO_CYCLES out of range 2..1023");
    end

    localparam logic [SLOT_W-1:0]  SLOT_SAT   = SLOT_W'(CPU_SLOT);
    localparam logic [BURST_W-1:0] BURST_SAT  = BURST_W'(BURST_MAX);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

    arb_state_e         state_q, state_d;
    logic [SLOT_W-1:0]  dwell_q, dwell_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               cpu_gnt_d;
    logic [1:0]         dma_gnt_d;
    logic [1:0]         owner_d;

    logic owner_req;
    logic ack_counted;
    logic pick_idx;
    logic pick_any;
    logic rr_grant;
    logic tmo_fire;

    assign dbg_state = state_q;

    // owner_o holds the granted master for the whole DMA tenure.
    assign owner_req   = (owner_o == OWN_DMA1) ? dma_req_i[1] : dma_req_i[0];
    assign ack_counted = owner_req && bus_ack_i;

    // The pointer moves on the SWITCH->DMA edge, when the grant is issued.
    assign rr_grant = (state_q == ST_SWITCH) && (owner_o != OWN_CPU);

    dma_rr_sel u_rr (
        .clk_p     (wb_clk_i),
        .rst       (wb_rst_i),
        .req       (dma_req_i),
        .grant_en  (rr_grant),
        .grant_idx (owner_o[1]),
        .pick_idx  (pick_idx),
        .pick_any  (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             stalled;

    // Stalled: the current owner has an open cycle that is not being acked.
    always_comb begin
        stalled = 1'b0;
        case (state_q)
            ST_CPU:  stalled = cpu_cyc_i && !bus_ack_i;
            ST_DMA:  stalled = owner_req && !bus_ack_i;
            default: stalled = 1'b0;
        endcase
    end

    // Fires on the cycle the count would reach TMO_CYCLES.
    assign tmo_fire = stalled && (tmo_q == TMO_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_q <= '0;
            tmo_o <= 1'b0;
        end else begin
            tmo_o <= tmo_fire;
            if (!stalled || tmo_fire) begin
                tmo_q <= '0;
            end else if (tmo_q < TMO_LAST) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign tmo_o    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        burst_d   = burst_q;
        cpu_gnt_d = cpu_gnt_o;
        dma_gnt_d = dma_gnt_o;
        owner_d   = owner_o;

        case (state_q)
            ST_CPU: begin
                if (dwell_q != SLOT_SAT) begin
                    dwell_d = dwell_q + SLOT_W'(1);
                end
                // A live CPU cycle blocks preemption; only the timeout overrides it.
                if (tmo_fire || (dwell_q == SLOT_SAT && !cpu_cyc_i && pick_any)) begin
                    state_d   = ST_SWITCH;
                    cpu_gnt_d = 1'b0;
                    dma_gnt_d = 2'b00;
                    if (!pick_any) begin
                        owner_d = OWN_CPU;
                    end else if (pick_idx) begin
                        owner_d = OWN_DMA1;
                    end else begin
                        owner_d = OWN_DMA0;
                    end
                end
            end

            ST_SWITCH: begin
                dwell_d = '0;
                burst_d = '0;
                if (owner_o == OWN_CPU) begin
                    state_d   = ST_CPU;
                    cpu_gnt_d = 1'b1;
                end else begin
                    state_d   = ST_DMA;
                    dma_gnt_d = (owner_o == OWN_DMA1) ? 2'b10 : 2'b01;
                end
            end

            ST_DMA: begin
                if (ack_counted && burst_q != BURST_SAT) begin
                    burst_d = burst_q + BURST_W'(1);
                end
                // Request drop, last burst ack and timeout all collapse into
                // one release; the tenure always returns to the CPU.
                if (!owner_req || (ack_counted && burst_q == BURST_LAST) || tmo_fire) begin
                    state_d   = ST_SWITCH;
                    dma_gnt_d = 2'b00;
                    owner_d   = OWN_CPU;
                end
            end

            default: begin
                state_d   = ST_CPU;
                cpu_gnt_d = 1'b1;
                dma_gnt_d = 2'b00;
                owner_d   = OWN_CPU;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_CPU;
            dwell_q   <= SLOT_SAT;
            burst_q   <= '0;
            cpu_gnt_o <= 1'b1;
            dma_gnt_o <= 2'b00;
            owner_o   <= OWN_CPU;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            burst_q   <= burst_d;
            cpu_gnt_o <= cpu_gnt_d;
            dma_gnt_o <= dma_gnt_d;
            owner_o   <= owner_d;
        end
    end

endmodule
